// File: rtl/gray_ptr_rx.sv
// gray_ptr_rx: brings a Gray-coded pointer into clk_i, decodes it to binary and reports the
// per-cycle advance. Optional illegal-transition checker built when GRAY_ERR_CHK_EN is defined.
module gray_ptr_rx #(
    parameter int VEC_W       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [VEC_W-1:0] gray_i,
    input  logic             err_clr_i,
    output logic [VEC_W-1:0] bin_o,
    output logic [VEC_W-1:0] delta_o,
    output logic             upd_o,
    output logic             valid_o,
    output logic             err_o
);

    localparam int CNT_W = $clog2(SYNC_STAGES + 1);

    typedef enum logic {
        ST_WARMUP = 1'b0,
        ST_RUN    = 1'b1
    } state_t;

    function automatic logic [VEC_W-1:0] g2b(input logic [VEC_W-1:0] g);
        logic [VEC_W-1:0] b;
        b[VEC_W-1] = g[VEC_W-1];
        for (int i = VEC_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    state_t                            r_state;
    state_t                            w_state_nxt;
    logic [CNT_W-1:0]                  r_cnt;
    logic [CNT_W-1:0]                  w_cnt_nxt;
    logic [SYNC_STAGES-1:0][VEC_W-1:0] r_sync;
    logic [VEC_W-1:0]                  r_gray_q;
    logic [VEC_W-1:0]                  r_bin;
    logic [VEC_W-1:0]                  r_delta;
    logic                              r_upd;
    logic [VEC_W-1:0]                  w_gray_s;
    logic [VEC_W-1:0]                  w_bin_s;
    logic [VEC_W-1:0]                  w_delta;

    // Warm-up lasts until the first sample that travelled the whole chain reaches bin_o.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= ST_WARMUP;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            ST_WARMUP: begin
                if (r_cnt == CNT_W'(SYNC_STAGES)) begin
                    w_state_nxt = ST_RUN;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            ST_RUN: begin
                w_state_nxt = ST_RUN;
            end
            default: begin
                w_state_nxt = ST_WARMUP;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_sync <= '0;
        end else begin
            r_sync[0] <= gray_i;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
        end
    end

    assign w_gray_s = r_sync[SYNC_STAGES-1];
    assign w_bin_s  = g2b(w_gray_s);
    assign w_delta  = w_bin_s - r_bin;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_bin    <= '0;
            r_gray_q <= '0;
            r_delta  <= '0;
            r_upd    <= 1'b0;
        end else begin
            r_bin    <= w_bin_s;
            r_gray_q <= w_gray_s;
            if (r_state == ST_RUN) begin
                r_delta <= w_delta;
                r_upd   <= (w_bin_s != r_bin);
            end else begin
                r_delta <= '0;
                r_upd   <= 1'b0;
            end
        end
    end

`ifdef GRAY_ERR_CHK_EN
    logic [VEC_W-1:0] w_diff;
    logic             w_multi;
    logic             r_err;

    // x & (x-1) is non-zero exactly when x has two or more bits set.
    assign w_diff  = w_gray_s ^ r_gray_q;
    assign w_multi = |(w_diff & (w_diff - 1'b1));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_err <= 1'b0;
        end else if ((r_state == ST_RUN) && w_multi) begin
            r_err <= 1'b1;
        end else if (err_clr_i) begin
            r_err <= 1'b0;
        end
    end

    assign err_o = r_err;
`else
    logic w_unused;

    assign w_unused = err_clr_i ^ (^r_gray_q);
    assign err_o    = 1'b0;
`endif

    assign bin_o   = r_bin;
    assign delta_o = r_delta;
    assign upd_o   = r_upd;
    assign valid_o = (r_state == ST_RUN);

endmodule

// File: tb/tb_gray_ptr_rx.sv
// Scoreboard bench for gray_ptr_rx: stimulus pushes expected outputs, a monitor pops and compares.
module tb_gray_ptr_rx;
    localparam int W = 4;
    localparam int S = 2;

    logic         clk = 1'b0;
    logic         rst_ni;
    logic         err_clr_i;
    logic [W-1:0] gray_i;
    logic [W-1:0] bin_o;
    logic [W-1:0] delta_o;
    logic         upd_o;
    logic         valid_o;
    logic         err_o;

    gray_ptr_rx #(.VEC_W(W), .SYNC_STAGES(S)) dut (
        .clk_i    (clk),
        .rst_ni   (rst_ni),
        .gray_i   (gray_i),
        .err_clr_i(err_clr_i),
        .bin_o    (bin_o),
        .delta_o  (delta_o),
        .upd_o    (upd_o),
        .valid_o  (valid_o),
        .err_o    (err_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0] bin;
        logic [W-1:0] delta;
        logic         upd;
        logic         valid;
        logic         err;
    } exp_t;

    exp_t         exp_q[$];
    int           tests = 0;
    int           fails = 0;
    int           n     = 0;
    logic [W-1:0] hist[$];
    logic         m_err = 1'b0;

    function automatic logic [W-1:0] m_g2b(input logic [W-1:0] g);
        logic [W-1:0] b;
        b = '0;
        for (int s = 0; s < W; s++) b = b ^ (g >> s);
        return b;
    endfunction

    function automatic logic [W-1:0] m_b2g(input logic [W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // Gray value that was present at rising edge k after reset release (0 before edge 1).
    function automatic logic [W-1:0] gat(input int k);
        if (k < 1) return '0;
        return hist[k-1];
    endfunction

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %b, required %b (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic step(input logic [W-1:0] g, input logic clr, input logic rn);
        exp_t e;
        logic [W-1:0] bp;
        logic multi;
        @(negedge clk);
        gray_i    = g;
        err_clr_i = clr;
        rst_ni    = rn;
        if (!rn) begin
            #1;
            chk("rst_bin",   bin_o,   '0);
            chk("rst_delta", delta_o, '0);
            chk("rst_upd",   W'(upd_o),   '0);
            chk("rst_valid", W'(valid_o), '0);
            chk("rst_err",   W'(err_o),   '0);
            n = 0;
            hist.delete();
            m_err = 1'b0;
            e = '0;
        end else begin
            n++;
            hist.push_back(g);
            e.valid = (n >= S + 1);
            e.bin   = m_g2b(gat(n - S));
            if (n >= S + 2) begin
                bp      = m_g2b(gat(n - S - 1));
                e.delta = e.bin - bp;
                e.upd   = (e.bin != bp);
                multi   = ($countones(gat(n - S) ^ gat(n - S - 1)) > 1);
            end else begin
                e.delta = '0;
                e.upd   = 1'b0;
                multi   = 1'b0;
            end
`ifdef GRAY_ERR_CHK_EN
            if (multi) m_err = 1'b1;
            else if (clr) m_err = 1'b0;
`else
            m_err = 1'b0;
`endif
            e.err = m_err;
        end
        exp_q.push_back(e);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("bin",   bin_o,       e.bin);
                chk("delta", delta_o,     e.delta);
                chk("upd",   W'(upd_o),   W'(e.upd));
                chk("valid", W'(valid_o), W'(e.valid));
                chk("err",   W'(err_o),   W'(e.err));
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stim
        logic [W-1:0] cur;
        int r;
        rst_ni    = 1'b0;
        err_clr_i = 1'b0;
        gray_i    = 4'b0110;
        // warm-up with a constant value held through reset release
        step(4'b0110, 1'b0, 1'b0);
        step(4'b0110, 1'b0, 1'b0);
        repeat (6) step(4'b0110, 1'b0, 1'b1);
        // full sweep including the 15 -> 0 wrap
        for (int i = 0; i < 18; i++) step(m_b2g(W'(i % 16)), 1'b0, 1'b1);
        // hold
        repeat (8) step(4'b1100, 1'b0, 1'b1);
        // illegal jumps, clear, and jump during clear
        repeat (4) step(4'b0000, 1'b0, 1'b1);
        repeat (5) step(4'b0011, 1'b0, 1'b1);
        step(4'b0011, 1'b1, 1'b1);
        repeat (3) step(4'b0011, 1'b0, 1'b1);
        repeat (5) step(4'b0000, 1'b1, 1'b1);
        repeat (3) step(4'b0000, 1'b0, 1'b1);
        repeat (3) step(4'b0000, 1'b1, 1'b1);
        // sweep with reset asserted at i=7
        for (int i = 0; i < 16; i++) begin
            if (i == 7) begin
                step(m_b2g(W'(i)), 1'b0, 1'b0);
                step(m_b2g(W'(i)), 1'b0, 1'b0);
            end
            step(m_b2g(W'(i)), 1'b0, 1'b1);
        end
        // randomized traffic: mostly legal steps, some illegal jumps, clears and resets
        cur = 4'd5;
        for (int k = 0; k < 400; k++) begin
            r = int'($urandom_range(0, 99));
            if (r < 70)      cur = cur + 1'b1;
            else if (r < 80) cur = cur - 1'b1;
            else if (r < 92) cur = cur;
            else             cur = W'($urandom);
            step(m_b2g(cur), ($urandom_range(0, 9) == 0), (r >= 2));
        end
        repeat (4) step(m_b2g(cur), 1'b0, 1'b1);
        repeat (3) @(posedge clk);
        #2;
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
